aes128_iter_ctrl: RTL

Iterative AES-128 encryption controller. It accepts one 128-bit plaintext and cipher key through a valid/ready handshake and computes ciphertext over 10 clock cycles. One shared round datapath (subBytes with inv=0, shiftRowsE, mixColumnsE) and one key-expansion step are reused each cycle, instead of ten unrolled round stages. It sits between the message source and the ciphertext sink and gives a fully combinational encryption path a registered, area-reduced alternative.

---
 rtl/aes128_iter_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round datapath and one key-expansion
// step reused over 10 cycles, with valid/ready handshakes on both sides.
module aes128_iter_ctrl (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         InValid,
  output logic         InReady,
  input  logic [127:0] InputMessage,
  input  logic [127:0] CipherKey,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] CodedMessage,
  output logic [3:0]   Round,
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid here depend only on state, never on the partner.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_e         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;

  logic [127:0] next_key;
  logic [127:0] sr_out;
  logic [127:0] mc_out;

  // Entry 0 sits in the top byte, so the MSB of entry b is 2047 - 8*b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i of the column-major state lives at bits [127-8i -: 8]; row r of
  // column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [7:0]   b [16];
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = b[r + 4*((c+r)%4)];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign next_key = key_step(key_q, rcon(rnd_q));
  assign sr_out   = shift_rows(sub_bytes(blk_q));
  assign mc_out   = mix_columns(sr_out);

  always_comb begin
    fsm_d = fsm_q;
    blk_d = blk_q;
    key_d = key_q;
    rnd_d = rnd_q;
    case (fsm_q)
      IDLE: begin
        if (InValid) begin
          blk_d = InputMessage ^ CipherKey;
          key_d = CipherKey;
          rnd_d = 4'd1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        key_d = next_key;
        rnd_d = rnd_q + 4'd1;
        // Final round skips MixColumns.
        if (rnd_q == 4'd10) begin
          blk_d = sr_out ^ next_key;
          fsm_d = DONE;
        end else begin
          blk_d = mc_out ^ next_key;
        end
      end
      DONE: begin
        if (OutReady) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      fsm_q <= IDLE;
      blk_q <= '0;
      key_q <= '0;
      rnd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      key_q <= key_d;
      rnd_q <= rnd_d;
    end
  end

  assign InReady      = (fsm_q == IDLE);
  assign OutValid     = (fsm_q == DONE);
  assign CodedMessage = blk_q;
  assign Round        = rnd_q;
  assign dbg_state    = fsm_q;

endmodule
